// File: rtl/gpio_in_filter.sv
// Per-bit GPIO input conditioning: synchronizer, debounce filter, edge detect
// and sticky interrupt-pending bits with write-1-to-clear.
module gpio_in_filter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     pad_c_i,
  input  logic [CNT_WIDTH-1:0] deb_cyc_i,
  input  logic [WIDTH-1:0]     rise_en_i,
  input  logic [WIDTH-1:0]     fall_en_i,
  input  logic [WIDTH-1:0]     irq_clr_i,
  output logic [WIDTH-1:0]     data_o,
  output logic [WIDTH-1:0]     rise_o,
  output logic [WIDTH-1:0]     fall_o,
  output logic [WIDTH-1:0]     pending_o,
  output logic                 irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_stable;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_pending;
  logic [WIDTH-1:0][CNT_WIDTH-1:0]   r_cnt;

  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_stable_nxt;
  logic [WIDTH-1:0][CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]                  w_rise;
  logic [WIDTH-1:0]                  w_fall;
  logic [WIDTH-1:0]                  w_set;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = r_stable & ~r_prev;
  assign w_fall = ~r_stable & r_prev;
  assign w_set  = (w_rise & rise_en_i) | (w_fall & fall_en_i);

  // Debounce: accept a change once the mismatch has outlasted deb_cyc_i edges
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    for (int b = 0; b < WIDTH; b++) begin
      if (w_sync[b] == r_stable[b]) begin
        w_cnt_nxt[b] = '0;
      end else if (r_cnt[b] >= deb_cyc_i) begin
        w_stable_nxt[b] = w_sync[b];
        w_cnt_nxt[b]    = '0;
      end else if (r_cnt[b] != CNT_MAX) begin
        w_cnt_nxt[b] = r_cnt[b] + CNT_ONE;
      end else begin
        w_cnt_nxt[b] = r_cnt[b];
      end
    end
  end

  // State registers; pending set takes priority over a coincident clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync    <= '0;
      r_stable  <= '0;
      r_prev    <= '0;
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], pad_c_i};
      r_stable  <= w_stable_nxt;
      r_prev    <= r_stable;
      r_pending <= w_set | (r_pending & ~irq_clr_i);
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign data_o    = r_stable;
  assign rise_o    = w_rise;
  assign fall_o    = w_fall;
  assign pending_o = r_pending;
  assign irq_o     = |r_pending;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed and randomized checks of gpio_in_filter against a cycle-level
// behavioural model built on run lengths of mismatching samples.
module tb_gpio_in_filter;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [W-1:0]  pad_c_i;
  logic [CW-1:0] deb_cyc_i;
  logic [W-1:0]  rise_en_i, fall_en_i, irq_clr_i;
  logic [W-1:0]  data_o, rise_o, fall_o, pending_o;
  logic          irq_o;

  int tests = 0;
  int fails = 0;

  // model state
  logic [W-1:0] m_hist [SS];
  logic [W-1:0] m_stable, m_prev, m_pend;
  int           m_run [W];

  gpio_in_filter #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pad_c_i(pad_c_i), .deb_cyc_i(deb_cyc_i),
    .rise_en_i(rise_en_i), .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i),
    .data_o(data_o), .rise_o(rise_o), .fall_o(fall_o),
    .pending_o(pending_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock edge: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    logic [W-1:0] r_now, f_now, s_out;
    @(posedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < SS; i++) m_hist[i] = '0;
      m_stable = '0; m_prev = '0; m_pend = '0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
    end else begin
      r_now  = m_stable & ~m_prev;
      f_now  = ~m_stable & m_prev;
      m_pend = (r_now & rise_en_i) | (f_now & fall_en_i) | (m_pend & ~irq_clr_i);
      m_prev = m_stable;
      s_out  = m_hist[SS-1];
      for (int b = 0; b < W; b++) begin
        if (s_out[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] > int'(deb_cyc_i)) begin
            m_stable[b] = s_out[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad_c_i;
    end
    #1;
    check("data", data_o, m_stable);
    check("rise", rise_o, m_stable & ~m_prev);
    check("fall", fall_o, ~m_stable & m_prev);
    check("pending", pending_o, m_pend);
    check("irq", {7'd0, irq_o}, {7'd0, |m_pend});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [W-1:0] seen;

  initial begin
    rst_i = 1'b1; pad_c_i = 8'hFF; deb_cyc_i = 16'd0;
    rise_en_i = 8'h00; fall_en_i = 8'h00; irq_clr_i = 8'h00;
    for (int i = 0; i < SS; i++) m_hist[i] = '0;
    m_stable = '0; m_prev = '0; m_pend = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;

    // reset with pads high, then N=0 latency of three edges
    steps(3);
    rst_i = 1'b0;
    steps(2);
    check("rst_data_early", data_o, 8'h00);
    step();
    check("rst_data_3cyc", data_o, 8'hFF);
    check("rst_rise", rise_o, 8'hFF);
    step();
    check("rst_rise_once", rise_o, 8'h00);
    check("rst_pending", pending_o, 8'h00);

    // latency with N=4 on bit0
    deb_cyc_i = 16'd4; pad_c_i = 8'hFE;
    steps(12);
    pad_c_i = 8'hFF;
    steps(6);
    check("lat_before", {7'd0, data_o[0]}, 8'h00);
    step();
    check("lat_7cyc", {7'd0, data_o[0]}, 8'h01);
    check("lat_rise", rise_o, 8'h01);
    step();
    check("lat_rise_once", rise_o, 8'h00);

    // glitch rejection on bit3, then a 5-cycle pulse is accepted
    pad_c_i = 8'hF7;
    steps(12);
    pad_c_i = 8'hFF;
    seen = '0;
    for (int i = 0; i < 4; i++) begin step(); seen |= rise_o | fall_o; end
    pad_c_i = 8'hF7;
    for (int i = 0; i < 10; i++) begin step(); seen |= rise_o | fall_o; end
    check("glitch_data", {7'd0, data_o[3]}, 8'h00);
    check("glitch_edges", seen, 8'h00);
    pad_c_i = 8'hFF;
    seen = '0;
    for (int i = 0; i < 5; i++) begin step(); seen |= rise_o; end
    pad_c_i = 8'hF7;
    for (int i = 0; i < 6; i++) begin step(); seen |= rise_o; end
    check("pulse5_rise", seen, 8'h08);
    steps(12);

    // interrupt path
    deb_cyc_i = 16'd0; pad_c_i = 8'h02;
    steps(6);
    rise_en_i = 8'h01; fall_en_i = 8'h02;
    pad_c_i = 8'h01;
    steps(3);
    check("irq_pulses", rise_o & 8'h01 | fall_o & 8'h02, 8'h03);
    check("irq_not_yet", pending_o, 8'h00);
    step();
    check("irq_pending", pending_o, 8'h03);
    check("irq_line", {7'd0, irq_o}, 8'h01);
    irq_clr_i = 8'h01;
    step();
    irq_clr_i = 8'h00;
    check("irq_clear", pending_o, 8'h02);

    // set/clear collision on bit0
    pad_c_i = 8'h00;
    steps(5);
    pad_c_i = 8'h01;
    steps(3);
    irq_clr_i = 8'h01;
    step();
    irq_clr_i = 8'h00;
    check("collision", pending_o, 8'h03);
    irq_clr_i = 8'hFF;
    step();
    irq_clr_i = 8'h00; rise_en_i = 8'h00; fall_en_i = 8'h00;

    // threshold lowered mid-count on bit2
    deb_cyc_i = 16'd100; pad_c_i = 8'h05;
    steps(52);
    check("thr_hold", {5'd0, data_o[2], 2'd0}, 8'h00);
    deb_cyc_i = 16'd10;
    step();
    check("thr_accept", {5'd0, data_o[2], 2'd0}, 8'h04);
    deb_cyc_i = 16'd100; pad_c_i = 8'h01;
    steps(52);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst_mid_data", data_o, 8'h00);
    steps(60);

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) deb_cyc_i = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        rise_en_i = 8'($urandom); fall_en_i = 8'($urandom);
      end
      pad_c_i   = pad_c_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      irq_clr_i = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rst_i     = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
